// File: rtl/pipelined_decode_unit.sv
// pipelined_decode_unit: ID stage of the 16-bit MISC-V pipeline.
// Owns the IF/ID register, the 8-entry register file, immediate generation,
// decode-time branch/jump resolution, hazard detection and the ID/EX register.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-low reset
//   if_*                fetched instruction (valid, pc, pc+2, ir)
//   ex_stall            downstream hold: both pipeline registers freeze
//   wb_*                register-file write port (write-first on read)
//   exmem_*             EX/MEM producer info for forwarding and hazards
//   id_stall            fetch must hold its PC and if_* values
//   redirect_valid/pc   taken branch/jump resolved in decode this cycle
//   idex_*              ID/EX register contents
module pipelined_decode_unit #(
    parameter int unsigned XLEN   = 16,
    parameter bit          FWD_EN = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_valid,
    input  logic [XLEN-1:0] if_pc,
    input  logic [XLEN-1:0] if_pcp2,
    input  logic [15:0]     if_ir,
    input  logic            ex_stall,
    input  logic            wb_we,
    input  logic [2:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            exmem_regwrite,
    input  logic            exmem_memread,
    input  logic [2:0]      exmem_rd,
    input  logic [XLEN-1:0] exmem_data,
    output logic            id_stall,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            idex_valid,
    output logic [XLEN-1:0] idex_pc,
    output logic [XLEN-1:0] idex_pcp2,
    output logic [XLEN-1:0] idex_rs1_val,
    output logic [XLEN-1:0] idex_rs2_val,
    output logic [XLEN-1:0] idex_imm,
    output logic [2:0]      idex_rs1,
    output logic [2:0]      idex_rs2,
    output logic [2:0]      idex_rd,
    output logic [2:0]      idex_aluop,
    output logic            idex_alusrc,
    output logic            idex_memread,
    output logic            idex_memwrite,
    output logic            idex_regwrite
);

    localparam int unsigned NREGS = 8;

    localparam logic [2:0] OP_R    = 3'd0;
    localparam logic [2:0] OP_I    = 3'd1;
    localparam logic [2:0] OP_LW   = 3'd2;
    localparam logic [2:0] OP_SW   = 3'd3;
    localparam logic [2:0] OP_BEQ  = 3'd4;
    localparam logic [2:0] OP_BNE  = 3'd5;
    localparam logic [2:0] OP_JAL  = 3'd6;
    localparam logic [2:0] OP_JALR = 3'd7;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pcp2;
        logic [XLEN-1:0] rs1_val;
        logic [XLEN-1:0] rs2_val;
        logic [XLEN-1:0] imm;
        logic [2:0]      rs1;
        logic [2:0]      rs2;
        logic [2:0]      rd;
        logic [2:0]      aluop;
        logic            alusrc;
        logic            memread;
        logic            memwrite;
        logic            regwrite;
    } idex_t;

    // IF/ID register
    logic            ifid_valid;
    logic [XLEN-1:0] ifid_pc;
    logic [XLEN-1:0] ifid_pcp2;
    logic [15:0]     ifid_ir;

    idex_t idex_q;
    idex_t idex_d;

    logic [XLEN-1:0] rf [NREGS];

    // Instruction fields
    logic [2:0] opcode;
    logic [2:0] f_rd;
    logic [2:0] f_rs1;
    logic [2:0] f_rs2;
    assign opcode = ifid_ir[2:0];
    assign f_rd   = ifid_ir[5:3];
    assign f_rs1  = ifid_ir[8:6];
    assign f_rs2  = ifid_ir[11:9];

    // Immediates, sign-extended to XLEN
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_j;
    assign imm_i = {{(XLEN-7){ifid_ir[15]}}, ifid_ir[15:9]};
    assign imm_s = {{(XLEN-7){ifid_ir[15]}}, ifid_ir[15:12], ifid_ir[5:3]};
    assign imm_j = {{(XLEN-10){ifid_ir[15]}}, ifid_ir[15:6]};

    // Which sources the instruction really reads; JAL reads none
    logic use_rs1;
    logic use_rs2;
    logic is_brj;
    assign use_rs1 = (opcode != OP_JAL);
    assign use_rs2 = (opcode == OP_R) || (opcode == OP_SW) ||
                     (opcode == OP_BEQ) || (opcode == OP_BNE);
    assign is_brj  = (opcode == OP_BEQ) || (opcode == OP_BNE) || (opcode == OP_JALR);

    // Register-file read with write-first bypass; r0 is hardwired to zero
    logic [XLEN-1:0] rs1_rf;
    logic [XLEN-1:0] rs2_rf;
    always_comb begin
        rs1_rf = '0;
        rs2_rf = '0;
        if (f_rs1 != 3'd0) begin
            rs1_rf = (wb_we && (wb_rd == f_rs1)) ? wb_data : rf[f_rs1];
        end
        if (f_rs2 != 3'd0) begin
            rs2_rf = (wb_we && (wb_rd == f_rs2)) ? wb_data : rf[f_rs2];
        end
    end

    // Decode-time operands for compare/JALR: an ALU result in EX/MEM wins
    logic            exmem_fwd_ok;
    logic [XLEN-1:0] rs1_op;
    logic [XLEN-1:0] rs2_op;
    assign exmem_fwd_ok = FWD_EN && exmem_regwrite && !exmem_memread && (exmem_rd != 3'd0);
    assign rs1_op = (exmem_fwd_ok && (exmem_rd == f_rs1)) ? exmem_data : rs1_rf;
    assign rs2_op = (exmem_fwd_ok && (exmem_rd == f_rs2)) ? exmem_data : rs2_rf;

    function automatic logic src_hit(input logic [2:0] prod_rd, input logic [2:0] src,
                                     input logic used);
        return used && (prod_rd != 3'd0) && (prod_rd == src);
    endfunction

    // Hazard detection
    logic hit_idex;
    logic hit_exmem;
    logic hazard;
    assign hit_idex  = src_hit(idex_q.rd, f_rs1, use_rs1) || src_hit(idex_q.rd, f_rs2, use_rs2);
    assign hit_exmem = src_hit(exmem_rd, f_rs1, use_rs1) || src_hit(exmem_rd, f_rs2, use_rs2);
    assign hazard = ifid_valid && (
                        (idex_q.memread && hit_idex) ||
                        (is_brj && idex_q.regwrite && hit_idex) ||
                        (is_brj && exmem_memread && hit_exmem) ||
                        (!FWD_EN && ((idex_q.regwrite && hit_idex) ||
                                     (exmem_regwrite && hit_exmem))));

    // Branch/jump resolution
    logic            taken;
    logic [XLEN-1:0] target;
    always_comb begin
        taken  = 1'b0;
        target = ifid_pc + imm_s;
        case (opcode)
            OP_BEQ:  taken = (rs1_op == rs2_op);
            OP_BNE:  taken = (rs1_op != rs2_op);
            OP_JAL: begin
                taken  = 1'b1;
                target = ifid_pc + imm_j;
            end
            OP_JALR: begin
                taken  = 1'b1;
                target = rs1_op + imm_i;
            end
            default: ;
        endcase
    end

    assign redirect_valid = ifid_valid && taken && !hazard && !ex_stall;
    assign redirect_pc    = target;
    // Gated by reset so an ex_stall held during reset does not leak out
    assign id_stall       = reset && (ex_stall || hazard);

    // Next ID/EX contents; bubbles are all-zero
    always_comb begin
        idex_d = '0;
        if (ifid_valid && !hazard) begin
            idex_d.valid   = 1'b1;
            idex_d.pc      = ifid_pc;
            idex_d.pcp2    = ifid_pcp2;
            idex_d.rs1_val = rs1_rf;
            idex_d.rs2_val = rs2_rf;
            idex_d.rs1     = f_rs1;
            idex_d.rs2     = f_rs2;
            idex_d.rd      = f_rd;
            case (opcode)
                OP_R: begin
                    idex_d.aluop    = ifid_ir[14:12];
                    idex_d.regwrite = 1'b1;
                end
                OP_I, OP_LW: begin
                    idex_d.imm      = imm_i;
                    idex_d.alusrc   = 1'b1;
                    idex_d.regwrite = 1'b1;
                    idex_d.memread  = (opcode == OP_LW);
                end
                OP_SW: begin
                    idex_d.imm      = imm_s;
                    idex_d.alusrc   = 1'b1;
                    idex_d.memwrite = 1'b1;
                end
                OP_BEQ, OP_BNE: idex_d.imm = imm_s;
                OP_JAL: begin
                    idex_d.imm      = imm_j;
                    idex_d.aluop    = 3'b111;
                    idex_d.regwrite = 1'b1;
                end
                default: begin
                    idex_d.imm      = imm_i;
                    idex_d.aluop    = 3'b111;
                    idex_d.regwrite = 1'b1;
                end
            endcase
        end
    end

    // Pipeline registers: ex_stall freezes both; a hazard freezes IF/ID only
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ifid_valid <= 1'b0;
            ifid_pc    <= '0;
            ifid_pcp2  <= '0;
            ifid_ir    <= '0;
            idex_q     <= '0;
        end else if (!ex_stall) begin
            idex_q <= idex_d;
            if (!hazard) begin
                // A taken redirect squashes the wrong-path fetch
                ifid_valid <= if_valid && !redirect_valid;
                ifid_pc    <= if_pc;
                ifid_pcp2  <= if_pcp2;
                ifid_ir    <= if_ir;
            end
        end
    end

    // Register file write port
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                rf[i] <= '0;
            end
        end else if (wb_we && (wb_rd != 3'd0)) begin
            rf[wb_rd] <= wb_data;
        end
    end

    assign idex_valid    = idex_q.valid;
    assign idex_pc       = idex_q.pc;
    assign idex_pcp2     = idex_q.pcp2;
    assign idex_rs1_val  = idex_q.rs1_val;
    assign idex_rs2_val  = idex_q.rs2_val;
    assign idex_imm      = idex_q.imm;
    assign idex_rs1      = idex_q.rs1;
    assign idex_rs2      = idex_q.rs2;
    assign idex_rd       = idex_q.rd;
    assign idex_aluop    = idex_q.aluop;
    assign idex_alusrc   = idex_q.alusrc;
    assign idex_memread  = idex_q.memread;
    assign idex_memwrite = idex_q.memwrite;
    assign idex_regwrite = idex_q.regwrite;

endmodule
